// File: rtl/fifo_stream_adapter.sv
// rtl/fifo_stream_adapter.sv - pops the fifo and re-presents its words as a valid/ready stream
module fifo_stream_adapter #(
  parameter int WIDTH     = 32,
  parameter int BUF_DEPTH = 3,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fifo_ready,
  output logic             fifo_read,
  input  logic [WIDTH-1:0] fifo_data,
  input  logic             fifo_valid,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  input  logic             flush,
  output logic [1:0]       buf_level,
  output logic [CNT_W-1:0] beat_count,
  output logic             proto_err
);

  localparam int               PTR_W    = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam logic [2:0]       DEPTH_L  = 3'(BUF_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BUF_DEPTH - 1);

  logic [WIDTH-1:0] mem [BUF_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [1:0]       level;
  logic             inflight;
  logic             drop_pending;
  logic             capture;
  logic             handshake;
  logic [2:0]       credits_used;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // A read is only issued when a slot is reserved for its return, so the
  // fifo's un-throttled data return can never overflow the buffer.
  always_comb begin
    credits_used = {1'b0, level} + {2'b00, inflight};
    fifo_read    = fifo_ready && !flush && (credits_used < DEPTH_L);
    capture      = fifo_valid && inflight && !drop_pending && !flush;
    handshake    = m_valid && m_ready;
  end

  assign m_valid   = (level != 2'd0);
  assign m_data    = mem[rd_ptr];
  assign buf_level = level;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      level        <= 2'd0;
      inflight     <= 1'b0;
      drop_pending <= 1'b0;
      beat_count   <= '0;
      proto_err    <= 1'b0;
    end else begin
      inflight     <= fifo_read;
      drop_pending <= flush && inflight;
      if (handshake) beat_count <= beat_count + CNT_W'(1);
      if (fifo_valid && !inflight) proto_err <= 1'b1;
      // A handshake during flush still counts above; everything else is dropped.
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        level  <= 2'd0;
      end else begin
        if (capture)   wr_ptr <= next_ptr(wr_ptr);
        if (handshake) rd_ptr <= next_ptr(rd_ptr);
        case ({capture, handshake})
          2'b10:   level <= level + 2'd1;
          2'b01:   level <= level - 2'd1;
          default: level <= level;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (capture) mem[wr_ptr] <= fifo_data;
  end

endmodule
